// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RV32 subset datapath (lw, sw, R, I-ALU, beq, jal).
// Memory-facing states stall on MemReady; write strobes are gated low while reset is held.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        st_fetch    = 4'd0,
        st_decode   = 4'd1,
        st_memadr   = 4'd2,
        st_memread  = 4'd3,
        st_memwb    = 4'd4,
        st_memwrite = 4'd5,
        st_executer = 4'd6,
        st_executei = 4'd7,
        st_aluwb    = 4'd8,
        st_beq      = 4'd9,
        st_jal      = 4'd10
    } state_t;

    localparam logic [6:0] op_lw   = 7'b0000011;
    localparam logic [6:0] op_sw   = 7'b0100011;
    localparam logic [6:0] op_r    = 7'b0110011;
    localparam logic [6:0] op_ialu = 7'b0010011;
    localparam logic [6:0] op_beq  = 7'b1100011;
    localparam logic [6:0] op_jal  = 7'b1101111;

    state_t     state;
    state_t     state_next;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) state <= st_fetch;
        else        state <= state_next;
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next = st_fetch;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        alu_op     = 2'b00;

        case (state)
            st_fetch: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ir_write   = MemReady;
                pc_write   = MemReady;
                state_next = MemReady ? st_decode : st_fetch;
            end
            st_decode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    op_lw, op_sw: state_next = st_memadr;
                    op_r:         state_next = st_executer;
                    op_ialu:      state_next = st_executei;
                    op_jal:       state_next = st_jal;
                    op_beq:       state_next = st_beq;
                    default:      state_next = st_fetch;
                endcase
            end
            st_memadr: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = (op == op_lw) ? st_memread : st_memwrite;
            end
            st_memread: begin
                AdrSrc     = 1'b1;
                state_next = MemReady ? st_memwb : st_memread;
            end
            st_memwb: begin
                ResultSrc  = 2'b01;
                reg_write  = 1'b1;
                state_next = st_fetch;
            end
            st_memwrite: begin
                AdrSrc     = 1'b1;
                mem_write  = 1'b1;
                state_next = MemReady ? st_fetch : st_memwrite;
            end
            st_executer: begin
                ALUSrcA    = 2'b10;
                alu_op     = 2'b10;
                state_next = st_aluwb;
            end
            st_executei: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                alu_op     = 2'b10;
                state_next = st_aluwb;
            end
            st_aluwb: begin
                reg_write  = 1'b1;
                state_next = st_fetch;
            end
            st_beq: begin
                ALUSrcA    = 2'b10;
                alu_op     = 2'b01;
                pc_write   = Zero;
                state_next = st_fetch;
            end
            st_jal: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_write   = 1'b1;
                state_next = st_aluwb;
            end
            default: state_next = st_fetch;
        endcase
    end

    // Only R-type with funct7b5 set subtracts; I-type reuses bit 30 as immediate.
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = ({op[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            op_sw:   ImmSrc = 2'b01;
            op_beq:  ImmSrc = 2'b10;
            op_jal:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign PCWrite  = reset & pc_write;
    assign IRWrite  = reset & ir_write;
    assign RegWrite = reset & reg_write;
    assign MemWrite = reset & mem_write;
    assign State    = state;

endmodule
